// File: rtl/full_adder_half_adder.sv
// ============================================================================
// Module      : half_adder
// Description : One-bit half adder, the building block of full_adder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic co
);

  assign s  = x ^ y;
  assign co = x & y;

endmodule

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module      : full_adder
// Description : One-bit full adder with combinational and registered outputs.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry,
  input  logic clk,
  input  logic rst,
  output logic sum_q,
  output logic carry_q
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (
    .x  (a),
    .y  (b),
    .s  (w_s0),
    .co (w_c0)
  );

  half_adder u_ha1 (
    .x  (w_s0),
    .y  (c),
    .s  (sum),
    .co (w_c1)
  );

  // The two half-adder carries can never both be high, so OR is exact.
  assign carry = w_c0 | w_c1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum;
      carry_q <= carry;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_full_adder.sv
// ============================================================================
// Module      : tb_full_adder
// Description : Scoreboard bench for full_adder, combinational and registered.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_full_adder;

  logic a, b, c, clk, rst;
  logic sum, carry, sum_q, carry_q;
  logic clk_en;

  int checks = 0;
  int passes = 0;

  logic [1:0] comb_q[$];
  logic [1:0] reg_q[$];
  logic [1:0] held;

  full_adder dut (
    .a       (a),
    .b       (b),
    .c       (c),
    .sum     (sum),
    .carry   (carry),
    .clk     (clk),
    .rst     (rst),
    .sum_q   (sum_q),
    .carry_q (carry_q)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  function automatic logic [1:0] add3(input logic x, input logic y, input logic z);
    add3 = {1'b0, x} + {1'b0, y} + {1'b0, z};
  endfunction

  // Expected register contents, captured from the inputs seen at each edge.
  always @(posedge clk) reg_q.push_back(rst ? 2'b00 : add3(a, b, c));

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic drive(input string tag, input logic x, input logic y, input logic z);
    logic [1:0] e;
    a = x; b = y; c = z;
    comb_q.push_back(add3(x, y, z));
    #1;
    e = comb_q.pop_front();
    check(tag, {carry, sum}, e);
  endtask

  task automatic tick(input string tag);
    logic [1:0] e;
    @(negedge clk);
    if (reg_q.size() == 0) begin
      checks++;
      $display("FAIL %s: got no capture expected one", tag);
    end else begin
      e = reg_q.pop_front();
      check(tag, {carry_q, sum_q}, e);
    end
  endtask

  initial begin
    clk_en = 1'b1;
    rst = 1'b1;
    a = 1'b0; b = 1'b0; c = 1'b0;
    tick("reset_state");

    rst = 1'b0;
    drive("comb_111", 1'b1, 1'b1, 1'b1);
    tick("capture_111");
    check("capture_111_const", {carry_q, sum_q}, 2'b11);

    rst = 1'b1;
    drive("comb_100_in_rst", 1'b1, 1'b0, 1'b0);
    tick("rst_override");
    check("rst_keeps_comb", {carry, sum}, 2'b01);

    rst = 1'b0;
    drive("comb_011", 1'b0, 1'b1, 1'b1);
    tick("capture_011");
    drive("glitch_comb_100", 1'b1, 1'b0, 1'b0);
    check("glitch_reg_hold", {carry_q, sum_q}, 2'b10);
    tick("capture_100");

    rst = 1'b1;
    tick("reset_again");
    rst = 1'b0;
    drive("comb_101", 1'b1, 1'b0, 1'b1);
    tick("release_101");
    check("release_101_const", {carry_q, sum_q}, 2'b10);

    for (int i = 0; i < 12; i++) begin
      drive("rand_comb", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      tick("rand_capture");
    end

    // Freeze the clock low and walk the whole truth table.
    clk_en = 1'b0;
    held = add3(a, b, c);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      drive("truth_table", v[2], v[1], v[0]);
      check("static_clk_hold", {carry_q, sum_q}, held);
      #9;
    end
    check("no_edge_while_static", 2'(reg_q.size()), 2'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
